// File: rtl/netwalk_flow_stats.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : netwalk_flow_stats                                           |
// | Description : Per-entry packet/byte flow counters indexed by TCAM match    |
// |               address, with power-up clear sweep, entry program/clear,     |
// |               registered read with optional clear, wrap or saturate mode.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module netwalk_flow_stats #(
  parameter int TCAM_ADDR_WIDTH = 6,
  parameter int PKT_CNT_WIDTH   = 32,
  parameter int BYTE_CNT_WIDTH  = 48,
  parameter int PKT_LEN_WIDTH   = 16,
  parameter int SATURATE        = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       stat_program_enable,
  input  logic [TCAM_ADDR_WIDTH-1:0] stat_program_addr,
  input  logic                       stat_of_match_found,
  input  logic [TCAM_ADDR_WIDTH-1:0] stat_of_match_addr,
  input  logic [PKT_LEN_WIDTH-1:0]   stat_pkt_len,
  output logic                       stat_count_valid,
  output logic [TCAM_ADDR_WIDTH-1:0] stat_count_addr,
  output logic [PKT_CNT_WIDTH-1:0]   stat_pkt_count,
  output logic [BYTE_CNT_WIDTH-1:0]  stat_byte_count,
  output logic                       stat_overflow,
  input  logic                       stat_read_en,
  input  logic [TCAM_ADDR_WIDTH-1:0] stat_read_addr,
  input  logic                       stat_read_clear,
  output logic                       stat_read_valid,
  output logic [PKT_CNT_WIDTH-1:0]   stat_read_pkt,
  output logic [BYTE_CNT_WIDTH-1:0]  stat_read_byte,
  output logic                       stat_ready
);

  localparam int                       c_DEPTH = 1 << TCAM_ADDR_WIDTH;
  localparam int                       c_PW1   = PKT_CNT_WIDTH + 1;
  localparam int                       c_BW1   = BYTE_CNT_WIDTH + 1;
  localparam bit                       c_SAT   = (SATURATE != 0);
  localparam logic [TCAM_ADDR_WIDTH-1:0] c_LAST = '1;

  typedef enum logic [0:0] {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t                      r_state, w_state_nxt;
  logic [TCAM_ADDR_WIDTH-1:0]  r_idx, w_idx_nxt;

  logic [PKT_CNT_WIDTH-1:0]    r_pkt_mem  [c_DEPTH];
  logic [BYTE_CNT_WIDTH-1:0]   r_byte_mem [c_DEPTH];

  logic                        r_cnt_valid;
  logic [TCAM_ADDR_WIDTH-1:0]  r_cnt_addr;
  logic [PKT_CNT_WIDTH-1:0]    r_cnt_pkt;
  logic [BYTE_CNT_WIDTH-1:0]   r_cnt_byte;
  logic                        r_cnt_ovf;
  logic                        r_rd_valid;
  logic [PKT_CNT_WIDTH-1:0]    r_rd_pkt;
  logic [BYTE_CNT_WIDTH-1:0]   r_rd_byte;

  logic                        w_run;
  logic                        w_prog;
  logic                        w_rd;
  logic                        w_rclr;
  logic                        w_match_ok;
  logic                        w_base_zero;
  logic [PKT_CNT_WIDTH-1:0]    w_pkt_base;
  logic [BYTE_CNT_WIDTH-1:0]   w_byte_base;
  logic [PKT_CNT_WIDTH:0]      w_pkt_sum;
  logic [BYTE_CNT_WIDTH:0]     w_byte_sum;
  logic [PKT_CNT_WIDTH-1:0]    w_pkt_new;
  logic [BYTE_CNT_WIDTH-1:0]   w_byte_new;
  logic                        w_ovf;

  // Strobes only count once the clear sweep has finished.
  assign w_run       = (r_state == S_RUN);
  assign w_prog      = w_run & stat_program_enable;
  assign w_rd        = w_run & stat_read_en;
  assign w_rclr      = w_rd & stat_read_clear;
  // A program to the matched entry wins and the match is dropped.
  assign w_match_ok  = w_run & stat_of_match_found &
                       ~(stat_program_enable & (stat_program_addr == stat_of_match_addr));
  // Read-clear of the matched entry: accumulate onto zero so the packet is not lost.
  assign w_base_zero = w_rclr & (stat_read_addr == stat_of_match_addr);
  assign w_pkt_base  = w_base_zero ? '0 : r_pkt_mem[stat_of_match_addr];
  assign w_byte_base = w_base_zero ? '0 : r_byte_mem[stat_of_match_addr];
  assign w_pkt_sum   = {1'b0, w_pkt_base} + c_PW1'(1);
  assign w_byte_sum  = {1'b0, w_byte_base} + c_BW1'(stat_pkt_len);
  assign w_pkt_new   = (c_SAT && w_pkt_sum[PKT_CNT_WIDTH]) ? '1 : w_pkt_sum[PKT_CNT_WIDTH-1:0];
  assign w_byte_new  = (c_SAT && w_byte_sum[BYTE_CNT_WIDTH]) ? '1 : w_byte_sum[BYTE_CNT_WIDTH-1:0];
  assign w_ovf       = w_pkt_sum[PKT_CNT_WIDTH] | w_byte_sum[BYTE_CNT_WIDTH];

  // State and sweep index register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_INIT;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // Next state: sweep every entry once, then run forever.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    case (r_state)
      S_INIT: begin
        w_idx_nxt = r_idx + TCAM_ADDR_WIDTH'(1);
        if (r_idx == c_LAST) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN:   w_state_nxt = S_RUN;
      default: w_state_nxt = S_INIT;
    endcase
  end

  // Entry storage: sweep clear, then clears, then the match result (later write wins).
  always_ff @(posedge clk) begin
    if (r_state == S_INIT) begin
      r_pkt_mem[r_idx]  <= '0;
      r_byte_mem[r_idx] <= '0;
    end else begin
      if (w_rclr) begin
        r_pkt_mem[stat_read_addr]  <= '0;
        r_byte_mem[stat_read_addr] <= '0;
      end
      if (w_prog) begin
        r_pkt_mem[stat_program_addr]  <= '0;
        r_byte_mem[stat_program_addr] <= '0;
      end
      if (w_match_ok) begin
        r_pkt_mem[stat_of_match_addr]  <= w_pkt_new;
        r_byte_mem[stat_of_match_addr] <= w_byte_new;
      end
    end
  end

  // Registered update report and read data; zero whenever not strobed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt_valid <= 1'b0;
      r_cnt_addr  <= '0;
      r_cnt_pkt   <= '0;
      r_cnt_byte  <= '0;
      r_cnt_ovf   <= 1'b0;
      r_rd_valid  <= 1'b0;
      r_rd_pkt    <= '0;
      r_rd_byte   <= '0;
    end else begin
      r_cnt_valid <= w_match_ok;
      r_cnt_addr  <= w_match_ok ? stat_of_match_addr : '0;
      r_cnt_pkt   <= w_match_ok ? w_pkt_new : '0;
      r_cnt_byte  <= w_match_ok ? w_byte_new : '0;
      r_cnt_ovf   <= w_match_ok & w_ovf;
      r_rd_valid  <= w_rd;
      r_rd_pkt    <= w_rd ? r_pkt_mem[stat_read_addr] : '0;
      r_rd_byte   <= w_rd ? r_byte_mem[stat_read_addr] : '0;
    end
  end

  assign stat_count_valid = r_cnt_valid;
  assign stat_count_addr  = r_cnt_addr;
  assign stat_pkt_count   = r_cnt_pkt;
  assign stat_byte_count  = r_cnt_byte;
  assign stat_overflow    = r_cnt_ovf;
  assign stat_read_valid  = r_rd_valid;
  assign stat_read_pkt    = r_rd_pkt;
  assign stat_read_byte   = r_rd_byte;
  assign stat_ready       = w_run;

endmodule
`default_nettype wire

// File: tb/tb_netwalk_flow_stats.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_netwalk_flow_stats                                        |
// | Description : Scoreboard bench for netwalk_flow_stats. Three instances     |
// |               share one stimulus stream: default widths/wrap, 4-bit pkt    |
// |               wrap, and 4-bit pkt / 20-bit byte saturate.                  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_netwalk_flow_stats;

  localparam int AW    = 6;
  localparam int LW    = 16;
  localparam int ND    = 3;
  localparam int DEPTH = 64;

  logic          clk = 1'b0;
  logic          reset;
  logic          prog_en;
  logic [AW-1:0] prog_addr;
  logic          match;
  logic [AW-1:0] match_addr;
  logic [LW-1:0] pkt_len;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic          rd_clr;

  always #5 clk = ~clk;

  // Per-instance outputs
  logic cv0, co0, rv0, rdy0, cv1, co1, rv1, rdy1, cv2, co2, rv2, rdy2;
  logic [AW-1:0] ca0, ca1, ca2;
  logic [31:0] cp0, rp0;
  logic [47:0] cb0, rb0;
  logic [3:0]  cp1, rp1, cp2, rp2;
  logic [19:0] cb1, rb1, cb2, rb2;

  netwalk_flow_stats #(.TCAM_ADDR_WIDTH(AW), .PKT_CNT_WIDTH(32), .BYTE_CNT_WIDTH(48),
                       .PKT_LEN_WIDTH(LW), .SATURATE(0)) u_dut0 (
    .clk(clk), .reset(reset),
    .stat_program_enable(prog_en), .stat_program_addr(prog_addr),
    .stat_of_match_found(match), .stat_of_match_addr(match_addr), .stat_pkt_len(pkt_len),
    .stat_count_valid(cv0), .stat_count_addr(ca0), .stat_pkt_count(cp0),
    .stat_byte_count(cb0), .stat_overflow(co0),
    .stat_read_en(rd_en), .stat_read_addr(rd_addr), .stat_read_clear(rd_clr),
    .stat_read_valid(rv0), .stat_read_pkt(rp0), .stat_read_byte(rb0), .stat_ready(rdy0));

  netwalk_flow_stats #(.TCAM_ADDR_WIDTH(AW), .PKT_CNT_WIDTH(4), .BYTE_CNT_WIDTH(20),
                       .PKT_LEN_WIDTH(LW), .SATURATE(0)) u_dut1 (
    .clk(clk), .reset(reset),
    .stat_program_enable(prog_en), .stat_program_addr(prog_addr),
    .stat_of_match_found(match), .stat_of_match_addr(match_addr), .stat_pkt_len(pkt_len),
    .stat_count_valid(cv1), .stat_count_addr(ca1), .stat_pkt_count(cp1),
    .stat_byte_count(cb1), .stat_overflow(co1),
    .stat_read_en(rd_en), .stat_read_addr(rd_addr), .stat_read_clear(rd_clr),
    .stat_read_valid(rv1), .stat_read_pkt(rp1), .stat_read_byte(rb1), .stat_ready(rdy1));

  netwalk_flow_stats #(.TCAM_ADDR_WIDTH(AW), .PKT_CNT_WIDTH(4), .BYTE_CNT_WIDTH(20),
                       .PKT_LEN_WIDTH(LW), .SATURATE(1)) u_dut2 (
    .clk(clk), .reset(reset),
    .stat_program_enable(prog_en), .stat_program_addr(prog_addr),
    .stat_of_match_found(match), .stat_of_match_addr(match_addr), .stat_pkt_len(pkt_len),
    .stat_count_valid(cv2), .stat_count_addr(ca2), .stat_pkt_count(cp2),
    .stat_byte_count(cb2), .stat_overflow(co2),
    .stat_read_en(rd_en), .stat_read_addr(rd_addr), .stat_read_clear(rd_clr),
    .stat_read_valid(rv2), .stat_read_pkt(rp2), .stat_read_byte(rb2), .stat_ready(rdy2));

  // Uniform views of the three instances
  logic [2:0]          cv, co, rv, rdy;
  logic [2:0][AW-1:0]  ca;
  logic [2:0][63:0]    cp, cb, rp, rb;

  always_comb begin
    cv = {cv2, cv1, cv0};
    co = {co2, co1, co0};
    rv = {rv2, rv1, rv0};
    rdy = {rdy2, rdy1, rdy0};
    ca[0] = ca0; ca[1] = ca1; ca[2] = ca2;
    cp[0] = 64'(cp0); cp[1] = 64'(cp1); cp[2] = 64'(cp2);
    cb[0] = 64'(cb0); cb[1] = 64'(cb1); cb[2] = 64'(cb2);
    rp[0] = 64'(rp0); rp[1] = 64'(rp1); rp[2] = 64'(rp2);
    rb[0] = 64'(rb0); rb[1] = 64'(rb1); rb[2] = 64'(rb2);
  end

  // ---------------- reference model ----------------
  function automatic int pw(input int d);
    return (d == 0) ? 32 : 4;
  endfunction
  function automatic int bw(input int d);
    return (d == 0) ? 48 : 20;
  endfunction
  function automatic bit sat(input int d);
    return (d == 2);
  endfunction
  function automatic longint unsigned maxv(input int w);
    return (64'd1 << w) - 64'd1;
  endfunction

  longint unsigned mpkt  [ND][DEPTH];
  longint unsigned mbyte [ND][DEPTH];

  typedef struct {
    int               stamp;
    logic [AW-1:0]    addr;
    logic [2:0][63:0] pkt;
    logic [2:0][63:0] byt;
    logic [2:0]       ovf;
  } cexp_t;

  typedef struct {
    int               stamp;
    logic [2:0][63:0] pkt;
    logic [2:0][63:0] byt;
  } rexp_t;

  cexp_t cq[$];
  rexp_t rq[$];

  int ncyc = 0;   // clock edges seen
  int cyc  = 0;   // edges since reset released
  int nvec = 0;
  int nfail = 0;

  task automatic model_clear();
    for (int d = 0; d < ND; d++)
      for (int a = 0; a < DEPTH; a++) begin
        mpkt[d][a]  = 0;
        mbyte[d][a] = 0;
      end
  endtask

  // Apply one clock of the rules to the model using the current inputs.
  task automatic model_update();
    rexp_t r;
    cexp_t c;
    bit    ok, zb;
    longint unsigned p, b;
    if (rd_en) begin
      r.stamp = ncyc + 1;
      for (int d = 0; d < ND; d++) begin
        r.pkt[d] = mpkt[d][rd_addr];
        r.byt[d] = mbyte[d][rd_addr];
      end
      rq.push_back(r);
    end
    ok = match && !(prog_en && (prog_addr == match_addr));
    zb = rd_en && rd_clr && (rd_addr == match_addr);
    c.stamp = ncyc + 1;
    c.addr  = match_addr;
    for (int d = 0; d < ND; d++) begin
      p = (zb ? 0 : mpkt[d][match_addr]) + 1;
      b = (zb ? 0 : mbyte[d][match_addr]) + longint'(pkt_len);
      c.ovf[d] = 1'b0;
      if (p > maxv(pw(d))) begin
        c.ovf[d] = 1'b1;
        p = sat(d) ? maxv(pw(d)) : (p & maxv(pw(d)));
      end
      if (b > maxv(bw(d))) begin
        c.ovf[d] = 1'b1;
        b = sat(d) ? maxv(bw(d)) : (b & maxv(bw(d)));
      end
      c.pkt[d] = p;
      c.byt[d] = b;
      if (rd_en && rd_clr) begin
        mpkt[d][rd_addr]  = 0;
        mbyte[d][rd_addr] = 0;
      end
      if (prog_en) begin
        mpkt[d][prog_addr]  = 0;
        mbyte[d][prog_addr] = 0;
      end
      if (ok) begin
        mpkt[d][match_addr]  = p;
        mbyte[d][match_addr] = b;
      end
    end
    if (ok) cq.push_back(c);
  endtask

  // ---------------- comparison helper ----------------
  task automatic chk(input string name, input int d, input logic [159:0] act,
                     input logic [159:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s dut%0d t=%0t actual=%h required=%h", name, d, $time, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  cexp_t me;
  rexp_t mr;
  bit    exp_rdy;

  always @(negedge clk) begin
    exp_rdy = !reset && (cyc >= DEPTH);
    for (int d = 0; d < ND; d++)
      chk("ready", d, 160'(rdy[d]), 160'(exp_rdy));

    if (cv != 3'b000) begin
      if (cq.size() == 0) begin
        chk("count_unexpected", 0, 160'(cv), 160'(0));
      end else begin
        me = cq.pop_front();
        for (int d = 0; d < ND; d++)
          chk("count", d, {cv[d], ca[d], cp[d], cb[d], co[d]},
              {1'b1, me.addr, me.pkt[d], me.byt[d], me.ovf[d]});
      end
    end else begin
      if (cq.size() > 0 && cq[0].stamp <= ncyc) begin
        me = cq.pop_front();
        chk("count_missing", 0, 160'(cv), 160'(3'b111));
      end
      for (int d = 0; d < ND; d++)
        chk("count_idle", d, {ca[d], cp[d], cb[d], co[d]}, 160'(0));
    end

    if (rv != 3'b000) begin
      if (rq.size() == 0) begin
        chk("read_unexpected", 0, 160'(rv), 160'(0));
      end else begin
        mr = rq.pop_front();
        for (int d = 0; d < ND; d++)
          chk("read", d, {rv[d], rp[d], rb[d]}, {1'b1, mr.pkt[d], mr.byt[d]});
      end
    end else begin
      if (rq.size() > 0 && rq[0].stamp <= ncyc) begin
        mr = rq.pop_front();
        chk("read_missing", 0, 160'(rv), 160'(3'b111));
      end
      for (int d = 0; d < ND; d++)
        chk("read_idle", d, {rp[d], rb[d]}, 160'(0));
    end
  end

  // ---------------- driver ----------------
  task automatic idle();
    prog_en = 0; prog_addr = '0; match = 0; match_addr = '0; pkt_len = '0;
    rd_en = 0; rd_addr = '0; rd_clr = 0;
  endtask

  task automatic step();
    if (!reset && cyc >= DEPTH) model_update();
    @(posedge clk);
    ncyc++;
    if (!reset) cyc++;
    #1;
  endtask

  task automatic do_match(input logic [AW-1:0] a, input logic [LW-1:0] len);
    idle();
    match = 1; match_addr = a; pkt_len = len;
    step();
    idle();
  endtask

  task automatic do_read(input logic [AW-1:0] a, input bit clr);
    idle();
    rd_en = 1; rd_addr = a; rd_clr = clr;
    step();
    idle();
  endtask

  task automatic rand_inputs();
    match      = ($urandom_range(0, 9) < 6);
    match_addr = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
    pkt_len    = ($urandom_range(0, 7) == 0) ? 16'hFFFF : LW'($urandom);
    prog_en    = ($urandom_range(0, 7) == 0);
    prog_addr  = AW'($urandom_range(0, 7));
    rd_en      = ($urandom_range(0, 3) == 0);
    rd_addr    = AW'($urandom_range(0, 7));
    rd_clr     = 1'($urandom_range(0, 1));
  endtask

  task automatic do_reset(input int hold);
    idle();
    step();
    reset = 1;
    cyc = 0;
    repeat (hold) step();
    reset = 0;
    model_clear();
  endtask

  initial begin
    reset = 1;
    idle();
    model_clear();
    repeat (3) step();
    reset = 0;
    cyc = 0;

    // Clear sweep: strobes must be ignored, ready rises after DEPTH edges
    repeat (DEPTH) begin
      rand_inputs();
      step();
    end
    idle();
    for (int a = 0; a < DEPTH; a++) do_read(AW'(a), 1'b0);

    // Accumulation on one entry, back to back
    do_match(6'd5, 16'd64);
    do_match(6'd5, 16'd1500);
    do_match(6'd5, 16'd100);
    do_read(6'd5, 1'b0);

    // 16 matches: 4-bit counters wrap / saturate on the 16th
    repeat (16) do_match(6'd2, 16'd10);
    do_read(6'd2, 1'b0);

    // Read-clear colliding with a match
    repeat (4) do_match(6'd7, 16'd100);
    idle();
    rd_en = 1; rd_addr = 6'd7; rd_clr = 1;
    match = 1; match_addr = 6'd7; pkt_len = 16'd60;
    step();
    do_read(6'd7, 1'b0);

    // Program vs match, same and different address
    do_match(6'd3, 16'd200);
    do_match(6'd4, 16'd300);
    idle();
    prog_en = 1; prog_addr = 6'd3; match = 1; match_addr = 6'd3; pkt_len = 16'd77;
    step();
    idle();
    prog_en = 1; prog_addr = 6'd3; match = 1; match_addr = 6'd4; pkt_len = 16'd33;
    step();
    do_read(6'd3, 1'b0);
    do_read(6'd4, 1'b0);

    // Read-clear together with program of the same entry
    do_match(6'd9, 16'd500);
    do_match(6'd9, 16'd501);
    idle();
    rd_en = 1; rd_addr = 6'd9; rd_clr = 1; prog_en = 1; prog_addr = 6'd9;
    step();
    do_read(6'd9, 1'b0);

    // Random traffic
    repeat (400) begin
      rand_inputs();
      step();
    end
    idle();
    for (int a = 0; a < 8; a++) do_read(AW'(a), 1'b0);

    // Reset during RUN
    do_reset(2);
    repeat (DEPTH) step();
    for (int a = 0; a < DEPTH; a++) do_read(AW'(a), 1'b0);

    // Reset during the sweep
    repeat (150) begin
      rand_inputs();
      step();
    end
    do_reset(1);
    repeat (20) step();
    do_reset(3);
    repeat (DEPTH) begin
      rand_inputs();
      step();
    end
    repeat (150) begin
      rand_inputs();
      step();
    end
    idle();
    for (int a = 0; a < 8; a++) do_read(AW'(a), 1'b0);

    repeat (3) step();
    chk("count_queue_drained", 0, 160'(cq.size()), 160'(0));
    chk("read_queue_drained", 0, 160'(rq.size()), 160'(0));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/netwalk_flow_stats.md
NETWALK_FLOW_STATS -- requirements
Module: netwalk_flow_stats

Interface
REQ-001 SHALL have parameter TCAM_ADDR_WIDTH, default 6, which sets the entry address width; depth is 2^TCAM_ADDR_WIDTH entries.
REQ-002 SHALL have parameter PKT_CNT_WIDTH, default 32, which is the per-entry packet counter width.
REQ-003 SHALL have parameter BYTE_CNT_WIDTH, default 48, which is the per-entry byte counter width.
REQ-004 SHALL have parameter PKT_LEN_WIDTH, default 16, which is the packet length input width.
REQ-005 SHALL have parameter SATURATE, default 0, selecting overflow mode: 0 = wrap, 1 = saturate at all-ones.
REQ-006 SHALL have one clock; reset is asynchronous and active-high; ports named clk and reset.
REQ-007 Ports:
- clk  in  1  clock
- reset  in  1  async active-high reset
- stat_program_enable  in  1  clear entry strobe
- stat_program_addr  in  TCAM_ADDR_WIDTH  entry to clear
- stat_of_match_found  in  1  match update strobe
- stat_of_match_addr  in  TCAM_ADDR_WIDTH  matched entry
- stat_pkt_len  in  PKT_LEN_WIDTH  bytes of the matched packet
- stat_count_valid  out  1  update-result strobe
- stat_count_addr  out  TCAM_ADDR_WIDTH  updated entry
- stat_pkt_count  out  PKT_CNT_WIDTH  post-update packet count
- stat_byte_count  out  BYTE_CNT_WIDTH  post-update byte count
- stat_overflow  out  1  update wrapped or saturated either counter
- stat_read_en  in  1  read request
- stat_read_addr  in  TCAM_ADDR_WIDTH  entry to read
- stat_read_clear  in  1  clear entry after read (qualified by stat_read_en)
- stat_read_valid  out  1  read data strobe
- stat_read_pkt  out  PKT_CNT_WIDTH  read packet count
- stat_read_byte  out  BYTE_CNT_WIDTH  read byte count
- stat_ready  out  1  init sweep done; inputs accepted

Function
REQ-008 Each entry SHALL hold a packet counter and a byte counter.
REQ-009 FSM SHALL have states INIT and RUN; reset forces INIT with sweep index 0.
REQ-010 In INIT the block SHALL zero one entry per cycle at the sweep index, incrementing it; after entry 2^TCAM_ADDR_WIDTH-1 it SHALL go to RUN, so stat_ready rises exactly 2^TCAM_ADDR_WIDTH cycles after reset deasserts.
REQ-011 In INIT all strobes (program, match, read) SHALL be ignored and all output strobes SHALL stay 0.
REQ-012 In RUN, a match SHALL add 1 to the packet counter and zero-extended stat_pkt_len to the byte counter of stat_of_match_addr in the same clock edge.
REQ-013 One cycle after a match, the block SHALL assert stat_count_valid for one cycle with stat_count_addr, the post-update counts, and stat_overflow; with no match it SHALL drive these outputs to 0.
REQ-014 When SATURATE=0, counters SHALL wrap modulo 2^width; when SATURATE=1, a counter whose sum exceeds all-ones SHALL hold all-ones; stat_overflow SHALL be 1 whenever either counter wraps or clamps.
REQ-015 stat_program_enable SHALL zero the addressed entry; if the same cycle carries a match to the same address, the clear SHALL win, the match SHALL be dropped, and stat_count_valid SHALL stay 0 in the following cycle.
REQ-016 A program and a match to different addresses in the same cycle SHALL both take effect.
REQ-017 A read SHALL be registered: stat_read_valid SHALL pulse one cycle after stat_read_en with the entry's value before that edge's updates; with no read the read outputs SHALL be 0.
REQ-018 On read-with-clear, the entry SHALL become zero; if a match to the same address occurs in the same cycle, the entry SHALL become {1, stat_pkt_len}, and stat_count_valid SHALL report those values, so no count is lost.
REQ-019 On read-with-clear combined with a program to the same address, the entry SHALL become zero and the read SHALL still return the pre-clear value.
REQ-020 Back-to-back matches to one address SHALL accumulate with no lost updates, at a throughput of one update per cycle.

Reset
REQ-021 While reset is high, all outputs SHALL be 0, including stat_ready; the entry array SHALL be considered invalid until INIT completes.
REQ-022 Assertion of reset mid-sweep or mid-RUN SHALL restart INIT from index 0 after deassertion.

Verification
REQ-023 Scenario: reset deasserted, default parameters -> stat_ready=0 for 64 cycles and 1 on cycle 64; reads of all entries return 0/0.
REQ-024 Scenario: 3 consecutive matches to addr 5 with lengths 64, 1500, 100 -> stat_count_valid pulses report (1,64), (2,1564), (3,1664); read of addr 5 returns (3,1664).
REQ-025 Scenario: SATURATE=0, PKT_CNT_WIDTH=4; 16 matches to addr 2 -> 16th report has pkt=0 and stat_overflow=1; with SATURATE=1 the result is pkt=15, overflow=1.
REQ-026 Scenario: read_clear on addr 7 (holding 4/400) in the same cycle as a match to addr 7, length 60 -> read returns (4,400); count report is (1,60); later read returns (1,60).
REQ-027 Scenario: program addr 3 and match addr 3 in the same cycle -> no count pulse; entry reads (0,0); a simultaneous match to addr 4 updates normally.
REQ-028 Scenario: reset pulsed during RUN after counts accumulate -> stat_ready low for 64 cycles, then all entries read 0.
